// File: rtl/w3d_mmio_arb_pkg.sv
// Shared types for the MMIO arbiter: FSM state encodings, grant index type
// and the round-robin pointer advance.
package w3d_mmio_arb_pkg;

    localparam int ARB_N_MAX = 8;

    typedef logic [$clog2(ARB_N_MAX)-1:0] gnt_idx_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    function automatic gnt_idx_t rr_next(input gnt_idx_t g, input int n);
        if (int'(g) >= n - 1) return '0;
        return g + gnt_idx_t'(1);
    endfunction

endpackage

// File: rtl/w3d_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping to the lowest index.
module w3d_rr_pick
    import w3d_mmio_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  gnt_idx_t     ptr,
    output gnt_idx_t     gnt,
    output logic         any
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // Upper segment [ptr..N-1] has priority over the wrapped segment [0..ptr-1].
        for (int j = 0; j < N; j++) begin
            if (!found && (j >= int'(ptr)) && req[j]) begin
                gnt   = gnt_idx_t'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && (j < int'(ptr)) && req[j]) begin
                gnt   = gnt_idx_t'(j);
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/w3d_mmio_arbiter.sv
// N-to-1 AXI4-Lite MMIO arbiter with independent round-robin read and write
// paths, one outstanding transaction each, channels passed through combinationally.
module w3d_mmio_arbiter
    import w3d_mmio_arb_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [N-1:0]        s_awvalid,
    output logic [N-1:0]        s_awready,
    input  logic [N*ADDR_W-1:0] s_awaddr,
    input  logic [N-1:0]        s_wvalid,
    output logic [N-1:0]        s_wready,
    input  logic [N*DATA_W-1:0] s_wdata,
    output logic [N-1:0]        s_bvalid,
    input  logic [N-1:0]        s_bready,
    input  logic [N-1:0]        s_arvalid,
    output logic [N-1:0]        s_arready,
    input  logic [N*ADDR_W-1:0] s_araddr,
    output logic [N-1:0]        s_rvalid,
    input  logic [N-1:0]        s_rready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic                mmio_awvalid,
    input  logic                mmio_awready,
    output logic [ADDR_W-1:0]   mmio_awaddr,
    output logic                mmio_wvalid,
    input  logic                mmio_wready,
    output logic [DATA_W-1:0]   mmio_wdata,
    input  logic                mmio_bvalid,
    output logic                mmio_bready,
    output logic                mmio_arvalid,
    input  logic                mmio_arready,
    output logic [ADDR_W-1:0]   mmio_araddr,
    input  logic                mmio_rvalid,
    output logic                mmio_rready,
    input  logic [DATA_W-1:0]   mmio_rdata,
    output wr_state_t           dbg_wr_state,
    output rd_state_t           dbg_rd_state,
    output gnt_idx_t            dbg_wgnt,
    output gnt_idx_t            dbg_rgnt,
    output gnt_idx_t            dbg_wptr,
    output gnt_idx_t            dbg_rptr
);

    wr_state_t    w_state;
    rd_state_t    r_state;
    gnt_idx_t     wgnt, rgnt, wptr, rptr, w_pick, r_pick;
    logic         w_any, r_any, aw_done, w_done;
    logic [N-1:0] wsel, rsel;
    logic         in_waddr, in_wresp, in_raddr, in_rdata;
    logic         aw_hs, w_hs, b_hs, ar_hs, r_hs;

    w3d_rr_pick #(.N(N)) u_wr_pick (.req(s_awvalid), .ptr(wptr), .gnt(w_pick), .any(w_any));
    w3d_rr_pick #(.N(N)) u_rd_pick (.req(s_arvalid), .ptr(rptr), .gnt(r_pick), .any(r_any));

    assign wsel     = {{(N-1){1'b0}}, 1'b1} << wgnt;
    assign rsel     = {{(N-1){1'b0}}, 1'b1} << rgnt;
    assign in_waddr = !srst && (w_state == W_ADDR);
    assign in_wresp = !srst && (w_state == W_RESP);
    assign in_raddr = !srst && (r_state == R_ADDR);
    assign in_rdata = !srst && (r_state == R_DATA);

    // Every channel transfers on the cycle where valid and ready are both high;
    // only the granted requester's lane is connected, all others read 0.
    assign mmio_awvalid = in_waddr && |(s_awvalid & wsel) && !aw_done;
    assign s_awready    = wsel & {N{in_waddr && mmio_awready && !aw_done}};
    assign mmio_wvalid  = in_waddr && |(s_wvalid & wsel) && !w_done;
    assign s_wready     = wsel & {N{in_waddr && mmio_wready && !w_done}};
    assign mmio_bready  = in_wresp && |(s_bready & wsel);
    assign s_bvalid     = wsel & {N{in_wresp && mmio_bvalid}};
    assign mmio_arvalid = in_raddr && |(s_arvalid & rsel);
    assign s_arready    = rsel & {N{in_raddr && mmio_arready}};
    assign mmio_rready  = in_rdata && |(s_rready & rsel);
    assign s_rvalid     = rsel & {N{in_rdata && mmio_rvalid}};
    assign s_rdata      = mmio_rdata;

    assign aw_hs = mmio_awvalid && mmio_awready;
    assign w_hs  = mmio_wvalid && mmio_wready;
    assign b_hs  = mmio_bvalid && mmio_bready;
    assign ar_hs = mmio_arvalid && mmio_arready;
    assign r_hs  = mmio_rvalid && mmio_rready;

    always_comb begin
        mmio_awaddr = '0;
        mmio_wdata  = '0;
        mmio_araddr = '0;
        for (int i = 0; i < N; i++) begin
            if (wgnt == gnt_idx_t'(i)) begin
                mmio_awaddr = s_awaddr[i*ADDR_W +: ADDR_W];
                mmio_wdata  = s_wdata[i*DATA_W +: DATA_W];
            end
            if (rgnt == gnt_idx_t'(i)) mmio_araddr = s_araddr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            w_state <= W_IDLE;
            wgnt    <= '0;
            wptr    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (w_any) begin
                    wgnt    <= w_pick;
                    w_state <= W_ADDR;
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) w_done <= 1'b1;
                    // AW and W may finish in either order or in the same cycle.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) w_state <= W_RESP;
                end
                W_RESP: if (b_hs) begin
                    wptr    <= rr_next(wgnt, N);
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= R_IDLE;
            rgnt    <= '0;
            rptr    <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (r_any) begin
                    rgnt    <= r_pick;
                    r_state <= R_ADDR;
                end
                R_ADDR: if (ar_hs) r_state <= R_DATA;
                R_DATA: if (r_hs) begin
                    rptr    <= rr_next(rgnt, N);
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign dbg_wr_state = w_state;
    assign dbg_rd_state = r_state;
    assign dbg_wgnt     = wgnt;
    assign dbg_rgnt     = rgnt;
    assign dbg_wptr     = wptr;
    assign dbg_rptr     = rptr;

endmodule

// File: tb/tb_w3d_mmio_arbiter.sv
// Directed bench for w3d_mmio_arbiter with N=2: inputs change on the falling
// edge, outputs are checked 1 ns later.
module tb_w3d_mmio_arbiter;
    import w3d_mmio_arb_pkg::*;

    logic        clk = 1'b0;
    logic        srst;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_awaddr, s_wdata, s_araddr;
    logic [31:0] s_rdata;
    logic        mmio_awvalid, mmio_awready, mmio_wvalid, mmio_wready;
    logic        mmio_bvalid, mmio_bready, mmio_arvalid, mmio_arready;
    logic        mmio_rvalid, mmio_rready;
    logic [31:0] mmio_awaddr, mmio_wdata, mmio_araddr, mmio_rdata;
    wr_state_t   dbg_wr_state;
    rd_state_t   dbg_rd_state;
    gnt_idx_t    dbg_wgnt, dbg_rgnt, dbg_wptr, dbg_rptr;

    int checks   = 0;
    int failures = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_pair;
    int seq[2];

    always #5 clk = ~clk;

    w3d_mmio_arbiter #(.N(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .srst(srst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .mmio_awvalid(mmio_awvalid), .mmio_awready(mmio_awready), .mmio_awaddr(mmio_awaddr),
        .mmio_wvalid(mmio_wvalid), .mmio_wready(mmio_wready), .mmio_wdata(mmio_wdata),
        .mmio_bvalid(mmio_bvalid), .mmio_bready(mmio_bready),
        .mmio_arvalid(mmio_arvalid), .mmio_arready(mmio_arready), .mmio_araddr(mmio_araddr),
        .mmio_rvalid(mmio_rvalid), .mmio_rready(mmio_rready), .mmio_rdata(mmio_rdata),
        .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state),
        .dbg_wgnt(dbg_wgnt), .dbg_rgnt(dbg_rgnt), .dbg_wptr(dbg_wptr), .dbg_rptr(dbg_rptr)
    );

    // Downstream handshake counters, used to catch duplicated transfers.
    always @(posedge clk) begin
        if (!srst && mmio_awvalid && mmio_awready) aw_cnt++;
        if (!srst && mmio_wvalid && mmio_wready) w_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, mmio_awvalid,
                    mmio_wvalid, mmio_bready, mmio_arvalid, mmio_rready}, 64'h0);
    endtask

    task automatic check_idle_ptrs(input string tag, input int wp, input int rp);
        check({tag, "_wstate"}, dbg_wr_state, W_IDLE);
        check({tag, "_rstate"}, dbg_rd_state, R_IDLE);
        check({tag, "_wptr"}, dbg_wptr, wp);
        check({tag, "_rptr"}, dbg_rptr, rp);
    endtask

    function automatic logic [31:0] c_addr(input int r, input int j);
        return 32'h1000 + 32'(r) * 32'h100 + 32'(j) * 32'h4;
    endfunction

    function automatic logic [31:0] c_data(input int r, input int j);
        return 32'hA000_0000 | (32'(r) << 16) | 32'(j);
    endfunction

    initial begin
        int g;
        int aw0, w0;
        srst = 1'b1;
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        mmio_awready = 1'b0; mmio_wready = 1'b0; mmio_bvalid = 1'b0;
        mmio_arready = 1'b0; mmio_rvalid = 1'b0; mmio_rdata = '0;

        // Reset
        repeat (3) @(negedge clk);
        #1 check_quiet("rst_hold");
        @(negedge clk); srst = 1'b0;
        #1 check_quiet("rst_first");
        check_idle_ptrs("rst", 0, 0);

        // Single write from requester 0
        @(negedge clk);
        s_awvalid = 2'b01; s_awaddr[31:0] = 32'h10;
        s_wvalid = 2'b01; s_wdata[31:0] = 32'hDEADBEEF;
        mmio_awready = 1'b1; mmio_wready = 1'b1; s_bready = 2'b01;
        #1 check("sw_idle_awvalid", mmio_awvalid, 0);
        check("sw_idle_awready", s_awready, 2'b00);
        @(negedge clk); #1;
        check("sw_awvalid", mmio_awvalid, 1);
        check("sw_aw_w", {mmio_awaddr, mmio_wdata}, {32'h10, 32'hDEADBEEF});
        check("sw_awready", s_awready, 2'b01);
        check("sw_wready", s_wready, 2'b01);
        @(negedge clk);
        s_awvalid = 2'b00; s_wvalid = 2'b00; mmio_bvalid = 1'b1;
        #1 check("sw_bvalid", s_bvalid, 2'b01);
        check("sw_bready", mmio_bready, 1);
        check("sw_awready1", s_awready, 2'b00);
        @(negedge clk); mmio_bvalid = 1'b0;
        #1 check_idle_ptrs("sw_done", 1, 0);
        check("sw_bvalid_off", s_bvalid, 2'b00);

        // W three cycles ahead of AW, requester 1
        @(negedge clk);
        aw0 = aw_cnt; w0 = w_cnt;
        s_awvalid = 2'b10; s_awaddr[63:32] = 32'h40;
        s_wvalid = 2'b10; s_wdata[63:32] = 32'h55AA55AA;
        mmio_awready = 1'b0; mmio_wready = 1'b1; s_bready = 2'b10;
        @(negedge clk); #1;
        check("skw_wready", s_wready, 2'b10);
        check("skw_awready_stall", s_awready, 2'b00);
        @(negedge clk); s_wvalid = 2'b00;
        #1 check("skw_wvalid_done", mmio_wvalid, 0);
        check("skw_awvalid_hold", mmio_awvalid, 1);
        @(negedge clk); #1;
        check("skw_wvalid_done2", mmio_wvalid, 0);
        @(negedge clk); mmio_awready = 1'b1;
        #1 check("skw_awready", s_awready, 2'b10);
        check("skw_awaddr", mmio_awaddr, 32'h40);
        @(negedge clk); s_awvalid = 2'b00; mmio_bvalid = 1'b1;
        #1 check("skw_bvalid", s_bvalid, 2'b10);
        @(negedge clk); mmio_bvalid = 1'b0;
        #1 check("skw_aw_count", aw_cnt - aw0, 1);
        check("skw_w_count", w_cnt - w0, 1);
        check_idle_ptrs("skw", 0, 0);

        // AW ahead of W with a 2-cycle W stall, requester 1
        @(negedge clk);
        aw0 = aw_cnt; w0 = w_cnt;
        s_awvalid = 2'b10; s_awaddr[63:32] = 32'h44;
        s_wvalid = 2'b10; s_wdata[63:32] = 32'h0BADF00D;
        mmio_awready = 1'b1; mmio_wready = 1'b0;
        @(negedge clk); #1;
        check("skb_awready", s_awready, 2'b10);
        check("skb_wready_stall", s_wready, 2'b00);
        @(negedge clk); s_awvalid = 2'b00;
        #1 check("skb_awvalid_done", mmio_awvalid, 0);
        check("skb_wvalid_hold", mmio_wvalid, 1);
        @(negedge clk); mmio_wready = 1'b1;
        #1 check("skb_wready", s_wready, 2'b10);
        check("skb_wdata", mmio_wdata, 32'h0BADF00D);
        @(negedge clk); s_wvalid = 2'b00; mmio_bvalid = 1'b1;
        #1 check("skb_bvalid", s_bvalid, 2'b10);
        @(negedge clk); mmio_bvalid = 1'b0;
        #1 check("skb_aw_count", aw_cnt - aw0, 1);
        check("skb_w_count", w_cnt - w0, 1);
        check_idle_ptrs("skb", 0, 0);

        // Both requesters write continuously: 3 each, grants alternate from 0
        for (int k = 0; k < 6; k++) exp_q.push_back({c_addr(k % 2, k / 2), c_data(k % 2, k / 2)});
        aw0 = aw_cnt;
        seq[0] = 0; seq[1] = 0;
        @(negedge clk);
        s_awaddr = {c_addr(1, 0), c_addr(0, 0)};
        s_wdata  = {c_data(1, 0), c_data(0, 0)};
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
        mmio_awready = 1'b1; mmio_wready = 1'b1; mmio_bvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            g = k % 2;
            #1 check("cont_idle", dbg_wr_state, W_IDLE);
            @(negedge clk); #1;
            check("cont_gnt", s_awready, 64'h1 << g);
            exp_pair = exp_q.pop_front();
            check("cont_pair", {mmio_awaddr, mmio_wdata}, exp_pair);
            @(negedge clk); #1;
            check("cont_bvalid", s_bvalid, 64'h1 << g);
            seq[g]++;
            if (seq[g] < 3) begin
                s_awaddr[g*32 +: 32] = c_addr(g, seq[g]);
                s_wdata[g*32 +: 32]  = c_data(g, seq[g]);
            end else begin
                s_awvalid[g] = 1'b0;
                s_wvalid[g]  = 1'b0;
            end
            @(negedge clk);
        end
        mmio_bvalid = 1'b0; s_bready = 2'b00;
        #1 check("cont_count", aw_cnt - aw0, 6);
        check_idle_ptrs("cont", 0, 0);

        // Requester 1 reads while requester 0 writes
        @(negedge clk);
        s_arvalid = 2'b10; s_araddr[63:32] = 32'h20;
        s_awvalid = 2'b01; s_awaddr[31:0] = 32'h30;
        s_wvalid = 2'b01; s_wdata[31:0] = 32'hCAFEF00D;
        mmio_arready = 1'b1; s_rready = 2'b11; s_bready = 2'b01;
        @(negedge clk); #1;
        check("par_arready", s_arready, 2'b10);
        check("par_araddr", mmio_araddr, 32'h20);
        check("par_awready", s_awready, 2'b01);
        check("par_awaddr", mmio_awaddr, 32'h30);
        @(negedge clk);
        s_arvalid = 2'b00; s_awvalid = 2'b00; s_wvalid = 2'b00;
        mmio_rvalid = 1'b1; mmio_rdata = 32'h12345678;
        #1 check("par_rvalid", s_rvalid, 2'b10);
        check("par_rdata", s_rdata, 32'h12345678);
        check("par_rready", mmio_rready, 1);
        check("par_bvalid_wait", s_bvalid, 2'b00);
        check("par_wstate", dbg_wr_state, W_RESP);
        @(negedge clk); mmio_rvalid = 1'b0; mmio_bvalid = 1'b1;
        #1 check("par_r_done", dbg_rd_state, R_IDLE);
        check("par_bvalid", s_bvalid, 2'b01);
        check("par_rvalid_off", s_rvalid, 2'b00);
        @(negedge clk); mmio_bvalid = 1'b0;
        #1 check_idle_ptrs("par", 1, 0);

        // Read backpressure on requester 0
        @(negedge clk);
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h50; s_rready = 2'b00;
        @(negedge clk); #1;
        check("bp_arready", s_arready, 2'b01);
        @(negedge clk); s_arvalid = 2'b00; mmio_rvalid = 1'b1; mmio_rdata = 32'h0F0F1234;
        for (int c = 0; c < 4; c++) begin
            #1 check("bp_rready_low", mmio_rready, 0);
            check("bp_rvalid_held", {s_rvalid, s_rdata}, {2'b01, 32'h0F0F1234});
            @(negedge clk);
        end
        s_rready = 2'b01;
        #1 check("bp_rready", mmio_rready, 1);
        @(negedge clk); mmio_rvalid = 1'b0;
        #1 check_idle_ptrs("bp", 1, 1);

        // Reset with write in W_RESP and read in R_ADDR
        @(negedge clk);
        s_awvalid = 2'b10; s_awaddr[63:32] = 32'h60; s_wvalid = 2'b10; s_bready = 2'b10;
        @(negedge clk);
        s_arvalid = 2'b01; s_araddr[31:0] = 32'h70; mmio_arready = 1'b0;
        @(negedge clk);
        s_awvalid = 2'b00; s_wvalid = 2'b00;
        #1 check("rm_wstate", dbg_wr_state, W_RESP);
        check("rm_rstate", dbg_rd_state, R_ADDR);
        srst = 1'b1;
        #1 check_quiet("rm_during");
        @(negedge clk); srst = 1'b0; mmio_arready = 1'b1;
        #1 check_quiet("rm_after");
        check_idle_ptrs("rm", 0, 0);
        check("rm_gnts", {dbg_wgnt, dbg_rgnt}, 0);
        @(negedge clk); #1;
        check("rm_regrant", s_arready, 2'b01);
        check("rm_araddr", {mmio_arvalid, mmio_araddr}, {1'b1, 32'h70});
        @(negedge clk); s_arvalid = 2'b00; mmio_rvalid = 1'b1; mmio_rdata = 32'h77; s_rready = 2'b01;
        #1 check("rm_rvalid", s_rvalid, 2'b01);
        @(negedge clk); mmio_rvalid = 1'b0;
        #1 check_idle_ptrs("rm_done", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
